// File: rtl/serial_mag_comparator_pkg.sv
// Shared encodings for the bit-serial magnitude comparator.
// The state and result encodings are reused by the top level and the bench.
package serial_mag_comparator_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPARE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    typedef enum logic [1:0] {
        StIdle    = IDLE,
        StCompare = COMPARE,
        StDone    = DONE
    } state_e;

    // One-hot ordering matches {abigger, asmaller, same}.
    typedef enum logic [2:0] {
        GT = 3'b100,
        LT = 3'b010,
        EQ = 3'b001
    } result_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_cmp_bit.sv
// One-bit magnitude decision cell; invert swaps the sense for a two's-complement sign bit.
module serial_cmp_bit (
    input  logic i_a_bit,
    input  logic i_b_bit,
    input  logic i_invert,
    output logic o_gt,
    output logic o_lt
);

    logic w_a_only;
    logic w_b_only;

    always_comb begin
        w_a_only = i_a_bit & ~i_b_bit;
        w_b_only = ~i_a_bit & i_b_bit;
        o_gt     = i_invert ? w_b_only : w_a_only;
        o_lt     = i_invert ? w_a_only : w_b_only;
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with unsigned/signed modes and optional early exit.
module serial_mag_comparator
    import serial_mag_comparator_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    input  logic                            i_signed_mode,
    input  logic [WIDTH-1:0]                i_a,
    input  logic [WIDTH-1:0]                i_b,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_abigger,
    output logic                            o_asmaller,
    output logic                            o_same,
    output logic [cnt_width(WIDTH)-1:0]     o_cycles
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

    state_e          r_state;
    state_e          w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic            r_signed;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_cnt;
    logic            r_found;
    logic            r_found_gt;
    logic [2:0]      r_result;
    logic [CW-1:0]   r_cycles;

    logic            w_gt;
    logic            w_lt;
    logic            w_invert;
    logic            w_last;
    logic [2:0]      w_result;

    assign w_invert = r_signed && (r_idx == IDX_MSB);

    serial_cmp_bit u_cmp_bit (
        .i_a_bit  (r_a[r_idx]),
        .i_b_bit  (r_b[r_idx]),
        .i_invert (w_invert),
        .o_gt     (w_gt),
        .o_lt     (w_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_last = (r_idx == '0) || (EARLY_EXIT && (w_gt || w_lt));
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (i_start) w_state_next = StCompare;
            StCompare: if (w_last)  w_state_next = StDone;
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // An earlier decision is sticky; otherwise the bit examined this cycle decides.
    always_comb begin
        w_result = EQ;
        if (r_found) begin
            w_result = r_found_gt ? GT : LT;
        end else if (w_gt) begin
            w_result = GT;
        end else if (w_lt) begin
            w_result = LT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_signed   <= 1'b0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_found    <= 1'b0;
            r_found_gt <= 1'b0;
            r_result   <= '0;
            r_cycles   <= '0;
        end else if (r_state == StIdle && i_start) begin
            r_a        <= i_a;
            r_b        <= i_b;
            r_signed   <= i_signed_mode;
            r_idx      <= IDX_MSB;
            r_cnt      <= '0;
            r_found    <= 1'b0;
            r_found_gt <= 1'b0;
        end else if (r_state == StCompare) begin
            r_idx <= r_idx - 1'b1;
            r_cnt <= r_cnt + 1'b1;
            if (!r_found && (w_gt || w_lt)) begin
                r_found    <= 1'b1;
                r_found_gt <= w_gt;
            end
            if (w_last) begin
                r_result <= w_result;
                r_cycles <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_busy     = (r_state != StIdle);
        o_done     = (r_state == StDone);
        o_abigger  = r_result[2];
        o_asmaller = r_result[1];
        o_same     = r_result[0];
        o_cycles   = r_cycles;
    end

endmodule

// File: doc/serial_mag_comparator.md
# serial_mag_comparator

Parametrised, bit-serial magnitude comparator. It is the sequential successor to the team's 2-bit combinational comparator. It latches two WIDTH-bit operands on a start pulse and examines one bit per clock, MSB first. It supports unsigned and two's-complement modes and can stop at the first differing bit. It reports a one-hot, registered greater/less/equal result with a done pulse. It sits beside datapath blocks that need area-cheap wide compares where latency is acceptable.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal values are ≥2.
- EARLY_EXIT, 1, when 1 the compare ends at the first differing bit; when 0 it always runs WIDTH bits (constant latency).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare; latched with the operands.
- a  input  WIDTH  operand A; latched on an accepted start.
- b  input  WIDTH  operand B; latched on an accepted start.
- busy  output  1  high in COMPARE and DONE.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- abigger  output  1  A > B.
- asmaller  output  1  A < B.
- same  output  1  A == B.
- cycles  output  $clog2(WIDTH+1)  number of bits examined in the last compare.

## Operation
- FSM states are IDLE, COMPARE and DONE.
- IDLE → COMPARE:
  - Taken on a rising edge with start=1.
  - On that edge, a, b and signed_mode are latched.
  - The bit index is set to WIDTH-1 and the examined count is set to 0.
- Each COMPARE cycle examines latched bit[idx] of A and B, then increments the count and decrements idx.
- Bit decision:
  - If the bits are equal, there is no decision.
  - If A=1 and B=0, the result is A-bigger. At idx=WIDTH-1 with signed_mode=1, the result is instead A-smaller.
  - If A=0 and B=1, the result is the mirror of the above.
- First decision wins. Bits after a decision never change the result.
- COMPARE → DONE happens on the edge that examines:
  - a deciding bit, when EARLY_EXIT=1; or
  - bit 0, in all other cases.
- Result:
  - If no bit decided, same=1.
  - abigger, asmaller, same and cycles load on the COMPARE→DONE edge.
  - They hold until the next DONE entry or reset.
  - After the first compare, exactly one of the three result flags is high.
- DONE → IDLE happens unconditionally on the next edge. done=1 only while in DONE.
- start is ignored in COMPARE and DONE. Changes to a, b or signed_mode after latching have no effect.
- Reset values:
  - state is IDLE.
  - busy, done, abigger, asmaller and same are all 0.
  - cycles is 0.
  - Internal operand registers are 0.

## Timing
- Latency: let the start edge be E0. done is high in the cycle after edge Ek.
  - k is the 1-based position of the first differing bit when EARLY_EXIT=1.
  - Otherwise k = WIDTH, and also k = WIDTH when the operands are equal.
- Throughput: at most one compare per k+2 cycles. The earliest next accepted start is the edge after DONE.
- busy rises the cycle after E0 and falls the cycle after done.
- Reset mid-operation:
  - Assertion of rst_n clears all outputs immediately, without waiting for clk.
  - The in-flight compare is discarded.
  - The first rising edge after release with start=1 begins a new compare normally.
- Signed and unsigned modes have identical latency. Only the MSB decision differs.

## Structure
- A shared package or include holds:
  - the state encoding localparams: IDLE=2'd0, COMPARE=2'd1, DONE=2'd2;
  - the result encoding: GT, LT, EQ;
  - a count-width helper for $clog2(WIDTH+1).
- One natural sub-module is serial_cmp_bit, a combinational 1-bit decision cell. Its inputs are a_bit, b_bit and invert (signed and MSB). It outputs gt and lt.
- The top level holds the FSM, the operand registers, the index/count counter and the result registers.

## Test plan
- Reset: hold rst_n=0 with start toggling → busy=0, done=0, abigger=asmaller=same=0, cycles=0 throughout.
- Unsigned, EARLY_EXIT=1, a=8'hA5, b=8'h25 → done in the cycle after E1, abigger=1, cycles=1. With EARLY_EXIT=0 → done after E8, abigger=1, cycles=8.
- Equal operands, a=b=8'h3C → done after E8, same=1, cycles=8.
- Signed mode, a=8'hFF, b=8'h01:
  - signed_mode=1 → asmaller=1, cycles=1.
  - The same operands with signed_mode=0 → abigger=1, cycles=1.
- Busy start, a=8'h10, b=8'h11:
  - Start, then re-assert start with a=8'hFF, b=8'h00 at E3 → second start is ignored.
  - Result is asmaller=1, cycles=8, and exactly one done pulse.
- Mid-op reset: start with a=8'h01, b=8'h00; drive rst_n=0 between E3 and E4 → outputs clear asynchronously.
  - After release, start with a=8'h80, b=8'h7F → abigger=1, cycles=1.
